// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback pipe vs. buffered long-latency results.
// Optional same-cycle bypass of LL results into an idle port: define WB_ARB_BYPASS_EN.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// ST_NORMAL | pipe has priority; FIFO head drains on cycles the pipe is idle
// ST_FORCE  | one-cycle pipeline freeze; FIFO head is written unconditionally
module wb_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             LL_VALID,
  input  logic [4:0]       LL_RD,
  input  logic [WIDTH-1:0] LL_DATA,
  output logic             LL_READY,
  output logic             RF_WE,
  output logic [4:0]       RF_A3,
  output logic [WIDTH-1:0] RF_WD3,
  output logic             STALL_W,
  output logic             LL_PENDING
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_port_arbiter: DEPTH must be a power of two and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("wb_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    starve_cnt, starve_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [4:0]       rd_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic empty, full, pw, ll_acc, push, pop, bypass;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign pw         = RegWriteW && (RdW != 5'd0);
  assign LL_READY   = !full && !RST;
  assign LL_PENDING = !empty && !RST;
  assign ll_acc     = LL_VALID && LL_READY;

  always_comb begin
    state_nxt  = ST_NORMAL;
    starve_nxt = starve_cnt;
    RF_WE      = 1'b0;
    RF_A3      = 5'd0;
    RF_WD3     = '0;
    STALL_W    = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    if (!RST) begin
      case (state)
        ST_FORCE: begin
          // Pipe write is held upstream by the freeze and retires next cycle.
          STALL_W    = 1'b1;
          starve_nxt = '0;
          if (!empty) begin
            RF_WE  = 1'b1;
            RF_A3  = rd_mem[rd_ptr];
            RF_WD3 = data_mem[rd_ptr];
            pop    = 1'b1;
          end
        end
        default: begin
          if (pw) begin
            RF_WE  = 1'b1;
            RF_A3  = RdW;
            RF_WD3 = ResultW;
            if (empty) begin
              starve_nxt = '0;
            end else if (starve_cnt == STARVE_TOP) begin
              starve_nxt = '0;
              state_nxt  = ST_FORCE;
            end else begin
              starve_nxt = starve_cnt + SW'(1);
            end
          end else if (!empty) begin
            RF_WE      = 1'b1;
            RF_A3      = rd_mem[rd_ptr];
            RF_WD3     = data_mem[rd_ptr];
            pop        = 1'b1;
            starve_nxt = '0;
          end else begin
            starve_nxt = '0;
`ifdef WB_ARB_BYPASS_EN
            if (ll_acc && LL_RD != 5'd0) begin
              RF_WE  = 1'b1;
              RF_A3  = LL_RD;
              RF_WD3 = LL_DATA;
              bypass = 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

  // Writes to r0 are accepted to keep the producer moving but never buffered.
  assign push = ll_acc && (LL_RD != 5'd0) && !bypass;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem[wr_ptr]   <= LL_RD;
      data_mem[wr_ptr] <= LL_DATA;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts every cycle's outputs.
module tb_wb_port_arbiter;
  localparam int WIDTH        = 32;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             RegWriteW;
  logic [4:0]       RdW;
  logic [WIDTH-1:0] ResultW;
  logic             LL_VALID;
  logic [4:0]       LL_RD;
  logic [WIDTH-1:0] LL_DATA;
  logic             LL_READY, RF_WE, STALL_W, LL_PENDING;
  logic [4:0]       RF_A3;
  logic [WIDTH-1:0] RF_WD3;

  wb_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .LL_VALID(LL_VALID), .LL_RD(LL_RD), .LL_DATA(LL_DATA), .LL_READY(LL_READY),
    .RF_WE(RF_WE), .RF_A3(RF_A3), .RF_WD3(RF_WD3), .STALL_W(STALL_W), .LL_PENDING(LL_PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        we;
    bit [4:0]  a3;
    bit [31:0] wd;
    bit        stall;
    bit        ready;
    bit        pend;
  } exp_t;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t m_fifo[$];
  int   m_starve = 0;
  bit   m_force = 0;
  bit   m_last_stall = 0;
  bit   m_last_acc = 0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stall_cyc[$];
  ent_t wr_log[$];
  bit   obs_we, obs_stall, obs_ready, obs_pend;
  bit [4:0]  obs_a3;
  bit [31:0] obs_wd;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: predicts this cycle's outputs from the current inputs, then advances.
  task automatic tick();
    exp_t e;
    ent_t h;
    bit   acc, pw, byp;
    e   = '{default: 0};
    acc = 0;
    byp = 0;
    if (RST) begin
      m_fifo.delete();
      m_starve = 0;
      m_force  = 0;
    end else begin
      e.ready = (m_fifo.size() < DEPTH);
      e.pend  = (m_fifo.size() != 0);
      acc     = LL_VALID && e.ready;
      pw      = RegWriteW && (RdW != 0);
      if (m_force) begin
        e.stall  = 1;
        m_force  = 0;
        m_starve = 0;
        if (m_fifo.size() != 0) begin
          h = m_fifo.pop_front();
          e.we = 1; e.a3 = h.rd; e.wd = h.data;
        end
      end else if (pw) begin
        e.we = 1; e.a3 = RdW; e.wd = ResultW;
        if (m_fifo.size() != 0) begin
          m_starve++;
          if (m_starve == STARVE_LIMIT) begin
            m_force  = 1;
            m_starve = 0;
          end
        end else begin
          m_starve = 0;
        end
      end else if (m_fifo.size() != 0) begin
        h = m_fifo.pop_front();
        e.we = 1; e.a3 = h.rd; e.wd = h.data;
        m_starve = 0;
      end else begin
        m_starve = 0;
`ifdef WB_ARB_BYPASS_EN
        if (acc && LL_RD != 0) begin
          e.we = 1; e.a3 = LL_RD; e.wd = LL_DATA;
          byp = 1;
        end
`endif
      end
      if (acc && LL_RD != 0 && !byp) m_fifo.push_back('{LL_RD, LL_DATA});
    end
    exp_q.push_back(e);
    m_last_stall = e.stall;
    m_last_acc   = acc;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  exp_t mon_e;
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      mon_e     = exp_q.pop_front();
      obs_we    = RF_WE;
      obs_a3    = RF_A3;
      obs_wd    = RF_WD3;
      obs_stall = STALL_W;
      obs_ready = LL_READY;
      obs_pend  = LL_PENDING;
      if (STALL_W) stall_cyc.push_back(cyc);
      if (RF_WE) wr_log.push_back('{RF_A3, RF_WD3});
      n_checks++;
      if (obs_we !== mon_e.we || obs_a3 !== mon_e.a3 || obs_wd !== mon_e.wd ||
          obs_stall !== mon_e.stall || obs_ready !== mon_e.ready || obs_pend !== mon_e.pend) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got we=%0b a3=%0d wd=%h stall=%0b ready=%0b pend=%0b, want we=%0b a3=%0d wd=%h stall=%0b ready=%0b pend=%0b",
                 cyc, RF_WE, RF_A3, RF_WD3, STALL_W, LL_READY, LL_PENDING,
                 mon_e.we, mon_e.a3, mon_e.wd, mon_e.stall, mon_e.ready, mon_e.pend);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  ent_t sent[$];
  int   ll_sent;
  int   budget;
  int   pipe_pct;

  initial begin
    RST = 1; RegWriteW = 0; RdW = 0; ResultW = 0; LL_VALID = 0; LL_RD = 0; LL_DATA = 0;
    @(posedge CLK);
    #1;

    // Reset with traffic presented
    RST = 1; LL_VALID = 1; LL_RD = 7; LL_DATA = 32'h1234_5678; RegWriteW = 1; RdW = 3; ResultW = 32'hAAAA_0001;
    tick();
    tick();
    check("reset_we", obs_we, 0);
    check("reset_ready", obs_ready, 0);
    check("reset_stall", obs_stall, 0);
    RST = 0; LL_VALID = 0; RegWriteW = 0;
    tick();
    check("post_reset_pending", obs_pend, 0);
    check("post_reset_we", obs_we, 0);

    // Idle port single LL result
    LL_VALID = 1; LL_RD = 5; LL_DATA = 32'hDEAD_BEEF;
    tick();
`ifdef WB_ARB_BYPASS_EN
    check("idle_bypass_we", obs_we, 1);
    check("idle_bypass_a3", obs_a3, 5);
    check("idle_bypass_wd", obs_wd, 32'hDEAD_BEEF);
    LL_VALID = 0;
    tick();
`else
    LL_VALID = 0;
    tick();
    check("idle_we", obs_we, 1);
    check("idle_a3", obs_a3, 5);
    check("idle_wd", obs_wd, 32'hDEAD_BEEF);
`endif
    tick();

    // Pipe priority, FIFO full, forced drains
    stall_cyc.delete();
    ll_sent = 0;
    RegWriteW = 1; RdW = 1; ResultW = 32'h5000_0000;
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && !m_last_stall) begin
        RdW = 5'(i % 31 + 1);
        ResultW = 32'h5000_0000 + 32'(i);
      end
      LL_VALID = (ll_sent < 2);
      LL_RD    = 5'(10 + ll_sent);
      LL_DATA  = 32'hC0DE_0000 + 32'(ll_sent);
      tick();
      if (m_last_acc) ll_sent++;
      if (i == 1) check("pipe_granted_a3", obs_a3, 2);
      if (i == 2) begin
        check("full_ready_low", obs_ready, 0);
        check("full_pending", obs_pend, 1);
      end
    end
    check("force_count", stall_cyc.size(), 2);
    if (stall_cyc.size() == 2) check("force_spacing", stall_cyc[1] - stall_cyc[0], STARVE_LIMIT + 1);
    RegWriteW = 0; LL_VALID = 0;
    tick();
    tick();

    // Destination register zero on both sources
    RegWriteW = 1; RdW = 0; ResultW = 32'hFFFF_FFFF;
    LL_VALID = 1; LL_RD = 0; LL_DATA = 32'hEEEE_EEEE;
    tick();
    tick();
    check("rd0_we", obs_we, 0);
    check("rd0_ready", obs_ready, 1);
    RegWriteW = 0; LL_VALID = 0;
    tick();
    check("rd0_pending", obs_pend, 0);

    // Back-to-back LL results across pointer wrap
    wr_log.delete();
    sent.delete();
    for (int i = 0; i < 10; i++) begin
      LL_VALID = 1;
      LL_RD    = 5'(i + 1);
      LL_DATA  = $urandom;
      budget   = 0;
      do begin
        tick();
        budget++;
      end while (!m_last_acc && budget < 20);
      if (!m_last_acc) check("wrap_accept_timeout", 0, 1);
      sent.push_back('{LL_RD, LL_DATA});
    end
    LL_VALID = 0;
    tick();
    tick();
    check("wrap_count", wr_log.size(), 10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
      check("wrap_a3", wr_log[i].rd, sent[i].rd);
      check("wrap_wd", wr_log[i].data, sent[i].data);
    end

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 480; i++) begin
      if (i % 80 == 0) pipe_pct = $urandom_range(20, 95);
      RST = ($urandom_range(0, 119) == 0);
      if (!m_last_stall) begin
        RegWriteW = ($urandom_range(0, 99) < pipe_pct);
        RdW       = 5'($urandom_range(0, 31));
        ResultW   = $urandom;
      end
      if (!(LL_VALID && !m_last_acc) || RST) begin
        LL_VALID = ($urandom_range(0, 1) == 1);
        LL_RD    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        LL_DATA  = $urandom;
      end
      tick();
    end

    // Drain
    RST = 0; RegWriteW = 0; LL_VALID = 0;
    budget = 0;
    while (m_fifo.size() != 0 && budget < 50) begin
      tick();
      budget++;
    end
    tick();
    check("drain_pending", obs_pend, 0);
    check("drain_we", obs_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
